// File: rtl/vec_pkg.sv
// Shared types and lane arithmetic for the vector alpha-composition pipeline.
package vec_pkg;

    // Every lane is an unsigned 8-bit pixel, 255 = full scale.
    localparam int LANE_W = 8;
    // Width of the per-lane intermediate held between stage 1 and the last stage.
    localparam int MID_W  = 17;

    typedef enum logic [2:0] {
        PASS_A = 3'd0,
        ADDS   = 3'd1,
        SUBS   = 3'd2,
        MULH   = 3'd3,
        BLEND  = 3'd4
    } vop_e;

    // How the last stage turns the stored intermediate into a pixel.
    typedef enum logic [1:0] {
        FIN_PASS    = 2'd0,
        FIN_SAT_ADD = 2'd1,
        FIN_SAT_SUB = 2'd2,
        FIN_DIV255  = 2'd3
    } fin_e;

    // Round-to-nearest x/255 for x <= 65025 without a divider.
    function automatic logic [LANE_W-1:0] div255(input logic [MID_W-1:0] x);
        logic [MID_W-1:0] t;
        logic [MID_W-1:0] s;
        t = x + MID_W'(128);
        s = t + (t >> 8);
        // s never exceeds 65407, so bit 16 is always clear.
        return s[15:8];
    endfunction

    // Final per-lane result from the intermediate and its finishing mode.
    function automatic logic [LANE_W-1:0] lane_finish(input fin_e mode, input logic [MID_W-1:0] x);
        logic [LANE_W-1:0] r;
        case (mode)
            FIN_SAT_ADD: r = x[8] ? 8'hFF : x[7:0];
            FIN_SAT_SUB: r = x[8] ? 8'h00 : x[7:0];
            FIN_DIV255:  r = div255(x);
            default:     r = x[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One pixel lane: operand capture (stage 0), products/sums (stage 1),
// optional delay stages, and the final saturated/rounded result (last stage).
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] ld_i,
    input  logic [2:0]        op_i,
    input  logic [LANE_W-1:0] alpha_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] res_o
);

    logic [LANE_W-1:0] a_q;
    logic [LANE_W-1:0] b_q;

    // Stage 0: capture this lane's operands when the op is accepted.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: data registers are reset too, because out_data must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (ld_i[0]) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    logic [8:0]        sum9;
    logic [8:0]        dif9;
    logic [15:0]       prod_ab;
    logic [15:0]       prod_a_alpha;
    logic [15:0]       prod_b_inv;
    logic [LANE_W-1:0] inv_alpha;

    assign sum9         = {1'b0, a_q} + {1'b0, b_q};
    assign dif9         = {1'b0, a_q} - {1'b0, b_q};
    assign inv_alpha    = 8'd255 - alpha_i;
    assign prod_ab      = 16'(a_q) * 16'(b_q);
    assign prod_a_alpha = 16'(a_q) * 16'(alpha_i);
    assign prod_b_inv   = 16'(b_q) * 16'(inv_alpha);

    logic [MID_W-1:0] mid_x;
    fin_e             mid_m;

    // Stage 0 -> 1 math: select the intermediate and how to finish it; op codes 5-7 pass a.
    // NOTE: both outputs get a default before the case so no latch is inferred.
    always_comb begin
        mid_x = {9'd0, a_q};
        mid_m = FIN_PASS;
        case (op_i)
            ADDS: begin
                mid_x = {8'd0, sum9};
                mid_m = FIN_SAT_ADD;
            end
            SUBS: begin
                mid_x = {8'd0, dif9};
                mid_m = FIN_SAT_SUB;
            end
            MULH: begin
                mid_x = {1'b0, prod_ab};
                mid_m = FIN_DIV255;
            end
            BLEND: begin
                mid_x = {1'b0, prod_a_alpha} + {1'b0, prod_b_inv};
                mid_m = FIN_DIV255;
            end
            default: begin
                mid_x = {9'd0, a_q};
                mid_m = FIN_PASS;
            end
        endcase
    end

    if (STAGES == 2) begin : g_short
        logic [LANE_W-1:0] res_q;

        // Two-stage pipe: stage 1 is also the last, so finish in the same step.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= '0;
            end else if (ld_i[1]) begin
                res_q <= lane_finish(mid_m, mid_x);
            end
        end

        assign res_o = res_q;
    end else begin : g_long
        localparam int NMID = STAGES - 2;

        // Index 0 is stage 1; higher indices are pure delay stages.
        logic [MID_W-1:0]  x_q [NMID];
        fin_e              m_q [NMID];
        logic [LANE_W-1:0] res_q;

        // Stage 1 intermediates, delay stages, and final result register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NMID; k++) begin
                    x_q[k] <= '0;
                    m_q[k] <= FIN_PASS;
                end
                res_q <= '0;
            end else begin
                if (ld_i[1]) begin
                    x_q[0] <= mid_x;
                    m_q[0] <= mid_m;
                end
                for (int k = 1; k < NMID; k++) begin
                    if (ld_i[k+1]) begin
                        x_q[k] <= x_q[k-1];
                        m_q[k] <= m_q[k-1];
                    end
                end
                if (ld_i[STAGES-1]) begin
                    res_q <= lane_finish(m_q[NMID-1], x_q[NMID-1]);
                end
            end
        end

        assign res_o = res_q;
    end

endmodule

// File: rtl/vec_blend_pipe.sv
// Vector execute pipeline for alpha composition: valid chain with
// valid/ready backpressure, jump flush, occupancy, and LANES lane ALUs.
module vec_blend_pipe
    import vec_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int PIX_W  = 8,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [LANES*PIX_W-1:0]       in_a,
    input  logic [LANES*PIX_W-1:0]       in_b,
    input  logic [PIX_W-1:0]             in_alpha,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*PIX_W-1:0]       out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int LAST  = STAGES - 1;
    localparam int OCC_W = $clog2(STAGES + 1);

    if (PIX_W != LANE_W) begin : g_bad_pix_w
        $error("vec_blend_pipe: PIX_W must be 8");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("vec_blend_pipe: STAGES must be at least 2");
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic              room_s0;
    logic              accept;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic [2:0]        op_q;
    logic [PIX_W-1:0]  alpha_q;
    logic [TAG_W-1:0]  tag_q [STAGES];

    // Advance chain from the output backwards: a stage moves when the next one has room.
    always_comb begin
        logic room;
        room = out_ready;
        adv  = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = valid_q[k] & room;
            room   = ~valid_q[k] | room;
        end
        room_s0 = room;
    end

    // Reset holds in_ready low; flush blocks acceptance for its whole cycle.
    assign in_ready = rst & ~flush & room_s0;
    assign accept   = in_valid & in_ready;

    // Data load enables, next valid bits (flush clears them all) and their popcount.
    always_comb begin
        ld      = '0;
        valid_d = '0;
        occ_d   = '0;
        ld[0]   = accept;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1] & ~flush;
        end
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = ~flush & (ld[k] | (valid_q[k] & ~adv[k]));
            occ_d      = occ_d + OCC_W'(valid_d[k]);
        end
    end

    // Valid chain and registered occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Stage 0 op/alpha capture and the tag shift chain; held while a stage stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            alpha_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                op_q     <= in_op;
                alpha_q  <= in_alpha;
                tag_q[0] <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vec_lane_alu #(
            .STAGES (STAGES)
        ) u_alu (
            .clk     (clk),
            .rst_n   (rst),
            .ld_i    (ld),
            .op_i    (op_q),
            .alpha_i (alpha_q),
            .a_i     (in_a[g*PIX_W +: PIX_W]),
            .b_i     (in_b[g*PIX_W +: PIX_W]),
            .res_o   (out_data[g*PIX_W +: PIX_W])
        );
    end

    assign out_valid = valid_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_vec_blend_pipe.sv
// Self-checking bench for vec_blend_pipe: directed steps plus a scoreboard
// fed on every accepted op and drained on every output handshake.
module tb_vec_blend_pipe;

    localparam int LANES  = 16;
    localparam int PIX_W  = 8;
    localparam int STAGES = 3;
    localparam int TAG_W  = 4;
    localparam int VW     = LANES * PIX_W;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [VW-1:0]    in_a;
    logic [VW-1:0]    in_b;
    logic [PIX_W-1:0] in_alpha;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [VW-1:0]    out_data;
    logic [TAG_W-1:0] out_tag;
    logic [OCC_W-1:0] occupancy;

    vec_blend_pipe #(
        .LANES  (LANES),
        .PIX_W  (PIX_W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_alpha  (in_alpha),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0]    data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   hs_cyc[$];
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   hs_count  = 0;
    int   acc_count = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, rounding by (x+127)/255.
    function automatic logic [VW-1:0] model(input logic [2:0] op, input logic [VW-1:0] a,
                                            input logic [VW-1:0] b, input logic [7:0] al);
        logic [VW-1:0] r;
        int x, y, v, ai;
        r  = '0;
        ai = int'(al);
        for (int i = 0; i < LANES; i++) begin
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
            case (op)
                3'd1:    v = (x + y > 255) ? 255 : x + y;
                3'd2:    v = (x > y) ? x - y : 0;
                3'd3:    v = (x * y + 127) / 255;
                3'd4:    v = (x * ai + y * (255 - ai) + 127) / 255;
                default: v = x;
            endcase
            r[i*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    // Monitor: compare on output handshakes, squash on flush/reset, push on accepts.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                n_cmp++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow: observed=output tag %0h expected=no output", out_tag);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_tag", VW'(out_tag), VW'(e.tag));
                end
            end
            if (flush) sb.delete();
            if (in_valid && in_ready) begin
                acc_count++;
                sb.push_back('{model(in_op, in_a, in_b, in_alpha), in_tag});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec(output logic [VW-1:0] v);
        for (int j = 0; j < VW / 32; j++) v[j*32 +: 32] = $urandom();
    endtask

    task automatic rand_op();
        logic [VW-1:0] v;
        in_op = 3'($urandom_range(0, 7));
        rand_vec(v);
        in_a = v;
        rand_vec(v);
        in_b = v;
        case ($urandom_range(0, 3))
            0:       in_alpha = 8'h00;
            1:       in_alpha = 8'hFF;
            default: in_alpha = 8'($urandom());
        endcase
        in_tag = TAG_W'($urandom());
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (sb.size() == 0 && occupancy == 0) break;
        end
        check({name, "_sb_empty"}, VW'(sb.size()), VW'(0));
        check({name, "_occ_zero"}, VW'(occupancy), VW'(0));
    endtask

    task automatic run_single(input logic [2:0] op, input logic [7:0] a8, input logic [7:0] b8,
                              input logic [7:0] al, input logic [TAG_W-1:0] tag,
                              input logic [7:0] exp8, input string name);
        logic [VW-1:0] expv;
        int lat;
        expv = {LANES{exp8}};
        tick();
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = {LANES{a8}};
        in_b      = {LANES{b8}};
        in_alpha  = al;
        in_tag    = tag;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, VW'(in_ready), VW'(1));
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({name, "_latency"}, VW'(lat), VW'(STAGES));
        check({name, "_data"}, out_data, expv);
        check({name, "_tag"}, VW'(out_tag), VW'(tag));
    endtask

    initial begin
        logic [VW-1:0]    hold_d;
        logic [TAG_W-1:0] hold_t;
        int drops, acc0, hs0;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_alpha  = '0;
        in_tag    = '0;
        #1 rst = 1'b0;
        #2;
        check("reset_out_valid", VW'(out_valid), VW'(0));
        check("reset_occupancy", VW'(occupancy), VW'(0));
        check("reset_out_data", out_data, VW'(0));
        check("reset_out_tag", VW'(out_tag), VW'(0));
        check("reset_in_ready", VW'(in_ready), VW'(0));
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", VW'(in_ready), VW'(1));

        // Directed single ops with latency, data and tag checks.
        run_single(3'd4, 8'hFF, 8'h00, 8'h80, 4'd5, 8'h80, "blend_half");
        run_single(3'd1, 8'hF0, 8'h20, 8'h00, 4'd1, 8'hFF, "adds_sat");
        run_single(3'd2, 8'h10, 8'h20, 8'h00, 4'd2, 8'h00, "subs_sat");
        run_single(3'd3, 8'hFF, 8'hFF, 8'h00, 4'd3, 8'hFF, "mulh_full");
        run_single(3'd3, 8'h80, 8'h80, 8'h00, 4'd4, 8'h40, "mulh_half");
        run_single(3'd7, 8'h5A, 8'hC3, 8'h11, 4'd6, 8'h5A, "op7_pass");
        drain("directed");

        // Ten back-to-back ops at full throughput.
        hs_cyc.delete();
        drops     = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            rand_op();
            in_tag   = TAG_W'(i);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) drops++;
        end
        tick();
        drain("stream");
        check("stream_ready_drops", VW'(drops), VW'(0));
        check("stream_count", VW'(hs_cyc.size()), VW'(10));
        if (hs_cyc.size() >= 10) check("stream_consecutive", VW'(hs_cyc[9] - hs_cyc[0]), VW'(9));

        // Backpressure: fill with out_ready low, hold, then release.
        acc0      = acc_count;
        hs0       = hs_count;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            rand_op();
            in_valid = 1'b1;
        end
        @(negedge clk);
        check("bp_occupancy", VW'(occupancy), VW'(STAGES));
        check("bp_in_ready", VW'(in_ready), VW'(0));
        check("bp_out_valid", VW'(out_valid), VW'(1));
        hold_d = out_data;
        hold_t = out_tag;
        repeat (3) @(negedge clk);
        check("bp_data_stable", out_data, hold_d);
        check("bp_tag_stable", VW'(out_tag), VW'(hold_t));
        tick();
        drain("bp");
        check("bp_accepted", VW'(acc_count - acc0), VW'(STAGES));
        check("bp_no_loss", VW'(hs_count - hs0), VW'(acc_count - acc0));

        // Flush of a full pipe with an op offered in the flush cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rand_op();
            in_valid = 1'b1;
        end
        tick();
        rand_op();
        flush    = 1'b1;
        in_valid = 1'b1;
        acc0     = acc_count;
        hs0      = hs_count;
        @(negedge clk);
        check("flush_in_ready", VW'(in_ready), VW'(0));
        check("flush_occ_before", VW'(occupancy), VW'(STAGES));
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_occ_after", VW'(occupancy), VW'(0));
        check("flush_out_valid", VW'(out_valid), VW'(0));
        repeat (4) tick();
        check("flush_not_accepted", VW'(acc_count), VW'(acc0));
        check("flush_no_output", VW'(hs_count), VW'(hs0));

        // Flush coinciding with an output handshake.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rand_op();
            in_valid = 1'b1;
        end
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        hs0       = hs_count;
        tick();
        flush = 1'b0;
        check("flush_hs_done", VW'(hs_count - hs0), VW'(1));
        @(negedge clk);
        check("flush_hs_occ", VW'(occupancy), VW'(0));
        check("flush_hs_valid", VW'(out_valid), VW'(0));

        // Asynchronous reset mid-stream, between clock edges.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            rand_op();
            in_valid = 1'b1;
        end
        #2;
        check("rst_pre_valid", VW'(out_valid), VW'(1));
        rst = 1'b0;
        #1;
        check("rst_async_valid", VW'(out_valid), VW'(0));
        check("rst_async_occ", VW'(occupancy), VW'(0));
        check("rst_async_data", out_data, VW'(0));
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_occ", VW'(occupancy), VW'(0));
        check("rst_release_ready", VW'(in_ready), VW'(1));

        // Random ops with random valid and ready against the reference model.
        acc0 = acc_count;
        hs0  = hs_count;
        for (int i = 0; i < 60; i++) begin
            tick();
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        drain("random");
        check("random_all_out", VW'(hs_count - hs0), VW'(acc_count - acc0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
